// File: rtl/compare_rr_arbiter.sv
// compare_rr_arbiter: one unsigned less-than comparator shared by NUM_REQ
// requesters. A round-robin arbiter grants one operand pair at a time, and the
// result comes back tagged with the winner's index.
module compare_rr_arbiter #(
  parameter  int DATA_WIDTH = 13,
  parameter  int NUM_REQ    = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic                          rsp_lt_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic                  rsp_lt_q, rsp_lt_d;

  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  handshake;

  // Round-robin search starting just after the last winner; only grants in IDLE
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    req_ready_o = '0;
    cand        = 0;
    if (state_q == IDLE) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = (int'(rr_ptr_q) + i) % NUM_REQ;
        if (!grant_valid && req_valid_i[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_WIDTH'(cand);
        end
      end
    end
    if (grant_valid) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign handshake = grant_valid & req_valid_i[grant_idx];

  // Next-state logic: latch the winner, compare for one cycle, hold the result
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    rsp_id_d = rsp_id_q;
    rsp_lt_d = rsp_lt_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d  = CMP;
          rr_ptr_d = grant_idx;
          id_d     = grant_idx;
          a_d      = req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          b_d      = req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      CMP: begin
        state_d  = RESP;
        rsp_id_d = id_q;
        rsp_lt_d = (a_q < b_q);
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, operand and result registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_WIDTH'(NUM_REQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id_q <= '0;
      rsp_lt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rsp_id_q <= rsp_id_d;
      rsp_lt_q <= rsp_lt_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_lt_o    = rsp_lt_q;

endmodule

// File: tb/tb_compare_rr_arbiter.sv
// Testbench for compare_rr_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_compare_rr_arbiter;

  localparam int DW = 13;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [NR*DW-1:0] req_a_i;
  logic [NR*DW-1:0] req_b_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [IW-1:0]    rsp_id_o;
  logic             rsp_lt_o;
  logic             busy_o;

  compare_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_lt_o    (rsp_lt_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mState 0 = free, 1 = accepted last edge, 2 = result offered
  int mState = 0;
  int rrPtr  = NR - 1;
  int pendId = 0;
  bit pendLt = 1'b0;
  int expId  = 0;
  bit expLt  = 1'b0;

  int checkCount = 0;
  int errorCount = 0;
  int cycleNo    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNo);
    end
  endtask

  function automatic int modelWinner(input logic [NR-1:0] v);
    if (mState != 0) return -1;
    for (int i = 1; i <= NR; i++) begin
      if (v[(rrPtr + i) % NR]) return (rrPtr + i) % NR;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check ready, advance model at the edge, check outputs
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*DW-1:0] a,
                               input logic [NR*DW-1:0] b, input logic rr,
                               input logic rs, output int granted);
    int win;
    logic [NR-1:0] expReady;
    @(negedge clk_i);
    req_valid_i = v;
    req_a_i     = a;
    req_b_i     = b;
    rsp_ready_i = rr;
    rst_i       = rs;
    #1;
    win      = modelWinner(v);
    expReady = '0;
    if (win >= 0) expReady[win] = 1'b1;
    checkOutput("req_ready", 32'(req_ready_o), 32'(expReady));
    granted = rs ? -1 : win;
    @(posedge clk_i);
    cycleNo++;
    if (rs) begin
      mState = 0;
      rrPtr  = NR - 1;
      expId  = 0;
      expLt  = 1'b0;
    end else if (mState == 0) begin
      if (win >= 0) begin
        pendId = win;
        pendLt = (a[win*DW +: DW] < b[win*DW +: DW]);
        rrPtr  = win;
        mState = 1;
      end
    end else if (mState == 1) begin
      expId  = pendId;
      expLt  = pendLt;
      mState = 2;
    end else if (rr) begin
      mState = 0;
    end
    #1;
    checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(mState == 2));
    checkOutput("busy", 32'(busy_o), 32'(mState != 0));
    checkOutput("rsp_id", 32'(rsp_id_o), 32'(expId));
    checkOutput("rsp_lt", 32'(rsp_lt_o), 32'(expLt));
  endtask

  // Single transaction from requester k with a known expected result
  task automatic runOne(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic lt, input string tag);
    logic [NR*DW-1:0] pa, pb;
    logic [NR-1:0] v;
    int g, n;
    pa = '0; pb = '0; v = '0;
    pa[k*DW +: DW] = a;
    pb[k*DW +: DW] = b;
    v[k] = 1'b1;
    g = -1; n = 0;
    while (g < 0 && n < 10) begin
      applyStimulus(v, pa, pb, 1'b0, 1'b0, g);
      n++;
    end
    checkOutput({tag, "_grant"}, 32'(g), 32'(k));
    n = 0;
    while (!rsp_valid_o && n < 10) begin
      applyStimulus('0, '0, '0, 1'b0, 1'b0, g);
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd1);
    checkOutput({tag, "_lt"}, 32'(rsp_lt_o), 32'(lt));
    checkOutput({tag, "_id"}, 32'(rsp_id_o), 32'(k));
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);
  endtask

  initial begin
    int g;
    int grants[$];
    int grantCycles[$];
    logic [NR-1:0]    curV;
    logic [NR*DW-1:0] curA, curB;
    logic [DW-1:0]    rv;

    rst_i = 1'b1; req_valid_i = '0; req_a_i = '0; req_b_i = '0; rsp_ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);

    // Test 1: reset state, then a single request from requester 0
    applyStimulus('0, '0, '0, 1'b0, 1'b1, g);
    runOne(0, 13'd5, 13'd9, 1'b1, "t1");

    // Test 2: all requesters valid, consumer always ready
    applyStimulus('0, '0, '0, 1'b0, 1'b1, g);
    for (int c = 0; c < 16; c++) begin
      applyStimulus('1, '0, '1, 1'b1, 1'b0, g);
      if (g >= 0) begin
        grants.push_back(g);
        grantCycles.push_back(cycleNo);
      end
    end
    checkOutput("t2_count", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      checkOutput("t2_order", 32'(grants[i]), 32'(i % NR));
      if (i > 0) checkOutput("t2_spacing", 32'(grantCycles[i] - grantCycles[i-1]), 32'd3);
    end
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);

    // Test 3: comparison boundaries
    runOne(1, 13'h1FFF, 13'h1FFF, 1'b0, "t3_max");
    runOne(1, 13'h0000, 13'h0000, 1'b0, "t3_zero");
    runOne(1, 13'h1FFE, 13'h1FFF, 1'b1, "t3_near");

    // Test 4: result held while consumer stalls, other requests blocked
    curA = '0; curB = '0;
    curA[2*DW +: DW] = 13'd100;
    curB[2*DW +: DW] = 13'd50;
    applyStimulus(4'b0100, curA, curB, 1'b0, 1'b0, g);
    checkOutput("t4_grant", 32'(g), 32'd2);
    applyStimulus('0, '0, '0, 1'b0, 1'b0, g);
    for (int i = 0; i < 5; i++) begin
      applyStimulus('1, '1, '0, 1'b0, 1'b0, g);
      checkOutput("t4_hold_id", 32'(rsp_id_o), 32'd2);
      checkOutput("t4_hold_lt", 32'(rsp_lt_o), 32'd0);
    end
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);

    // Test 5: reset while comparing discards the result
    applyStimulus(4'b1000, '0, '1, 1'b0, 1'b0, g);
    checkOutput("t5_grant", 32'(g), 32'd3);
    applyStimulus('0, '0, '0, 1'b1, 1'b1, g);
    checkOutput("t5_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, '0, 1'b1, 1'b0, g);
      checkOutput("t5_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    applyStimulus('1, '0, '0, 1'b1, 1'b0, g);
    checkOutput("t5_regrant", 32'(g), 32'd0);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);

    // Test 6: pointer at 3 wraps the search back to requester 2
    runOne(3, 13'd7, 13'd7, 1'b0, "t6_pre");
    runOne(2, 13'd1, 13'd2, 1'b1, "t6_wrap");
    applyStimulus('1, '0, '0, 1'b1, 1'b0, g);
    checkOutput("t6_next", 32'(g), 32'd3);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);
    applyStimulus('0, '0, '0, 1'b1, 1'b0, g);

    // Randomized traffic: requesters mostly hold until granted, occasionally withdraw
    curV = '0; curA = '0; curB = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!(curV[k] && $urandom_range(0, 9) != 0)) begin
          curV[k] = ($urandom_range(0, 2) == 0);
          case ($urandom_range(0, 3))
            0:       rv = '0;
            1:       rv = '1;
            default: rv = DW'($urandom);
          endcase
          curA[k*DW +: DW] = rv;
          curB[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? rv : DW'($urandom);
        end
      end
      applyStimulus(curV, curA, curB, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 149) == 0), g);
      if (g >= 0) curV[g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
